// File: rtl/loop_settle_sched.sv
// loop_settle_sched: clocked fixed-point settle loop for t1=fb+data, t2=t1^{WIDTH{ctrl}}; optional LOOP_SETTLE_OSC_DETECT_EN adds period-2 oscillation detection
module loop_settle_sched #(
  parameter int WIDTH    = 16,
  parameter int MAX_ITER = 8,
  parameter int ITW      = $clog2(MAX_ITER + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_control,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic [ITW-1:0]   o_iters,
  output logic             o_converged,
  output logic             o_osc,
  output logic             o_busy
);
  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_data, r_fb, r_result, w_t1, w_t2;
  logic [ITW-1:0]   r_iter, r_iters, w_n;
  logic             r_ctrl, r_conv, w_conv, w_lim, w_oscd, w_stop;
  assign w_t1   = r_fb + r_data;
  assign w_t2   = w_t1 ^ {WIDTH{r_ctrl}};
  assign w_n    = r_iter + ITW'(1);
  assign w_conv = w_t2 == r_fb;
  assign w_lim  = w_n == ITW'(MAX_ITER);
`ifdef LOOP_SETTLE_OSC_DETECT_EN
  logic [WIDTH-1:0] r_fb_prev;
  logic             r_prev_v, r_osc;
  assign w_oscd = r_prev_v && (w_t2 == r_fb_prev);
  assign o_osc  = r_osc;
  // previous feedback value and oscillation flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fb_prev <= '0;
      r_prev_v  <= 1'b0;
      r_osc     <= 1'b0;
    end else if (r_state == S_IDLE && i_valid) begin
      r_prev_v <= 1'b0;
    end else if (r_state == S_EVAL) begin
      if (w_stop) r_osc <= !w_conv && w_oscd;
      else begin
        r_fb_prev <= r_fb;
        r_prev_v  <= 1'b1;
      end
    end
  end
`else
  assign w_oscd = 1'b0;
  assign o_osc  = 1'b0;
`endif
  assign w_stop      = w_conv || w_oscd || w_lim;
  assign o_ready     = r_state == S_IDLE;
  assign o_busy      = r_state == S_EVAL;
  assign o_valid     = r_state == S_DONE;
  assign o_result    = r_result;
  assign o_iters     = r_iters;
  assign o_converged = r_conv;
  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end
  // next-state: accept in IDLE, stop EVAL on a terminating iteration, release DONE on i_ready
  always_comb begin
    w_next = r_state;
    if (r_state == S_IDLE && i_valid)      w_next = S_EVAL;
    else if (r_state == S_EVAL && w_stop)  w_next = S_DONE;
    else if (r_state == S_DONE && i_ready) w_next = S_IDLE;
  end
  // job capture, one iteration per EVAL cycle, result latch on termination
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data   <= '0;
      r_ctrl   <= 1'b0;
      r_fb     <= '0;
      r_iter   <= '0;
      r_result <= '0;
      r_iters  <= '0;
      r_conv   <= 1'b0;
    end else if (r_state == S_IDLE && i_valid) begin
      r_data <= i_data;
      r_ctrl <= i_control;
      r_fb   <= '0;
      r_iter <= '0;
    end else if (r_state == S_EVAL) begin
      if (w_stop) begin
        r_result <= w_t1 & w_t2;
        r_iters  <= w_n;
        r_conv   <= w_conv;
      end else begin
        r_fb   <= w_t2;
        r_iter <= w_n;
      end
    end
  end
endmodule

// File: tb/tb_loop_settle_sched.sv
// tb_loop_settle_sched: randomized and directed self-checking bench for loop_settle_sched
module tb_loop_settle_sched;
  localparam int W  = 16;
  localparam int M  = 8;
  localparam int IW = $clog2(M + 1);
  logic          clk = 1'b0, rst_n = 1'b0;
  logic          i_valid = 1'b0, i_control = 1'b0, i_ready = 1'b0;
  logic [W-1:0]  i_data = '0;
  logic          o_ready, o_valid, o_converged, o_osc, o_busy;
  logic [W-1:0]  o_result;
  logic [IW-1:0] o_iters;
  int checks = 0, failures = 0;
`ifdef LOOP_SETTLE_OSC_DETECT_EN
  localparam bit OSC_EN = 1'b1;
`else
  localparam bit OSC_EN = 1'b0;
`endif

  loop_settle_sched #(.WIDTH(W), .MAX_ITER(M)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_control(i_control), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_iters(o_iters), .o_converged(o_converged),
    .o_osc(o_osc), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // iterate the feedback equation directly until fixed point, oscillation or limit
  function automatic void model(input logic [W-1:0] d, input logic c, output logic [W-1:0] res,
                                output int it, output logic cv, output logic os);
    logic [W-1:0] fb, prev, t1, t2;
    bit pv;
    fb = '0; prev = '0; pv = 0; cv = 0; os = 0; res = '0; it = 0;
    for (int n = 1; n <= M; n++) begin
      t1 = fb + d;
      t2 = t1 ^ {W{c}};
      res = t1 & t2;
      it = n;
      if (t2 == fb) begin cv = 1; break; end
      if (OSC_EN && pv && t2 == prev) begin os = 1; break; end
      if (n == M) break;
      prev = fb; pv = 1; fb = t2;
    end
  endfunction

  // one job end to end; lat counts the accept cycle, so k iterations give k+1
  task automatic run_job(input logic [W-1:0] d, input logic c, output logic [W-1:0] res,
                         output int it, output logic cv, output logic os, output int lat);
    @(negedge clk);
    i_valid = 1'b1; i_data = d; i_control = c; i_ready = 1'b0;
    @(negedge clk);
    i_valid = 1'b0; i_data = W'($urandom); i_control = 1'($urandom);
    lat = 1;
    while (!o_valid && lat < 40) begin
      @(negedge clk);
      i_data = W'($urandom); i_control = 1'($urandom);
      lat++;
    end
    res = o_result; it = int'(o_iters); cv = o_converged; os = o_osc;
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_ready, o_valid, o_converged, o_osc, o_busy} !== 5'b10000) begin
      failures++; $display("FAIL reset_flags got=%b want=10000", {o_ready, o_valid, o_converged, o_osc, o_busy});
    end
    checks++;
    if (o_result !== '0 || o_iters !== '0) begin
      failures++; $display("FAIL reset_data got result=%h iters=%0d want 0/0", o_result, o_iters);
    end
  endtask

  task automatic test_directed;
    logic [W-1:0] dd [4] = '{16'h0000, 16'h0001, 16'h0000, 16'hFFFF};
    logic         cc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] er [4] = '{16'h0000, 16'h0008, 16'h0000, 16'h0000};
    int           ei [4] = '{1, 8, OSC_EN ? 2 : 8, 1};
    logic         ec [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic         eo [4] = '{1'b0, 1'b0, OSC_EN, 1'b0};
    logic [W-1:0] r; int it, lat; logic cv, os;
    for (int k = 0; k < 4; k++) begin
      run_job(dd[k], cc[k], r, it, cv, os, lat);
      checks++;
      if (lat !== ei[k] + 1) begin failures++; $display("FAIL dir%0d_latency got=%0d want=%0d", k, lat, ei[k] + 1); end
      checks++;
      if (r !== er[k]) begin failures++; $display("FAIL dir%0d_result got=%h want=%h", k, r, er[k]); end
      checks++;
      if (it !== ei[k]) begin failures++; $display("FAIL dir%0d_iters got=%0d want=%0d", k, it, ei[k]); end
      checks++;
      if ({cv, os} !== {ec[k], eo[k]}) begin failures++; $display("FAIL dir%0d_flags got=%b%b want=%b%b", k, cv, os, ec[k], eo[k]); end
      checks++;
      if (!o_ready || o_valid) begin failures++; $display("FAIL dir%0d_handoff got ready=%b valid=%b want 1/0", k, o_ready, o_valid); end
    end
  endtask

  task automatic test_hold;
    int n;
    @(negedge clk);
    i_valid = 1'b1; i_data = 16'hFFFF; i_control = 1'b1; i_ready = 1'b0;
    @(negedge clk);
    i_valid = 1'b0;
    n = 0;
    while (!o_valid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!o_valid) begin failures++; $display("FAIL hold_timeout got valid=0 want 1"); end
    for (int k = 0; k < 5; k++) begin
      i_data = W'($urandom); i_control = ~i_control;
      @(negedge clk);
      checks++;
      if (!o_valid || o_ready || o_result !== 16'h0000 || o_iters !== IW'(1) || !o_converged) begin
        failures++;
        $display("FAIL hold_stable cyc%0d got v=%b r=%b res=%h it=%0d cv=%b want 1/0/0000/1/1", k, o_valid, o_ready, o_result, o_iters, o_converged);
      end
    end
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    checks++;
    if (!o_ready || o_valid || o_iters !== IW'(1)) begin
      failures++; $display("FAIL hold_release got r=%b v=%b it=%0d want 1/0/1", o_ready, o_valid, o_iters);
    end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] r; int it, lat; logic cv, os; bit seen;
    @(negedge clk);
    i_valid = 1'b1; i_data = 16'h0001; i_control = 1'b0;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (!o_busy || o_valid) begin failures++; $display("FAIL mid_busy got busy=%b valid=%b want 1/0", o_busy, o_valid); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_ready, o_valid, o_busy, o_converged, o_osc} !== 5'b10000 || o_result !== '0 || o_iters !== '0) begin
      failures++; $display("FAIL mid_reset got flags=%b res=%h it=%0d want 10000/0/0", {o_ready, o_valid, o_busy, o_converged, o_osc}, o_result, o_iters);
    end
    seen = 0;
    repeat (3) begin @(negedge clk); seen |= o_valid; end
    rst_n = 1'b1;
    repeat (12) begin @(negedge clk); seen |= o_valid; end
    checks++;
    if (seen) begin failures++; $display("FAIL mid_dropped got valid=1 want 0"); end
    run_job(16'h0000, 1'b0, r, it, cv, os, lat);
    checks++;
    if (it !== 1 || !cv || lat !== 2) begin failures++; $display("FAIL mid_next got it=%0d cv=%b lat=%0d want 1/1/2", it, cv, lat); end
  endtask

  task automatic test_random;
    logic [W-1:0] d, r, er; int it, ei, lat; logic c, cv, os, ec, eo;
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 3))
        0:       d = 16'h0000;
        1:       d = 16'hFFFF;
        2:       d = W'($urandom_range(1, 5));
        default: d = W'($urandom);
      endcase
      c = 1'($urandom);
      model(d, c, er, ei, ec, eo);
      run_job(d, c, r, it, cv, os, lat);
      checks++;
      if (r !== er || it !== ei || cv !== ec || os !== eo || lat !== ei + 1) begin
        failures++;
        $display("FAIL rand%0d d=%h c=%b got res=%h it=%0d cv=%b os=%b lat=%0d want %h/%0d/%b/%b/%0d",
                 k, d, c, r, it, cv, os, lat, er, ei, ec, eo, ei + 1);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_hold;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
